// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_pkg
//  Description : Shared types, constants and pointer helpers for fifo_reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_rd_pkg;

    // Default configuration that matches the companion synchronous_FIFO.
    localparam int c_WIDTH     = 8;
    localparam int c_BUF_DEPTH = 3;
    localparam int c_PTR_W     = (c_BUF_DEPTH > 1) ? $clog2(c_BUF_DEPTH) : 1;

    // Data word carried from the FIFO to the stream output.
    typedef logic [c_WIDTH-1:0] word_t;

    // Pointer width for an arbitrary depth (at least one bit).
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter width: must be able to hold the value 'depth'.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Circular increment that also works when depth is not a power of two.
    function automatic int unsigned ptr_wrap_inc(input int unsigned ptr,
                                                 input int unsigned depth);
        return (ptr + 1 >= depth) ? 32'd0 : ptr + 1;
    endfunction

endpackage : fifo_rd_pkg
`default_nettype wire

// File: rtl/fifo_rd_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_skid_buf
//  Description : Small circular buffer that absorbs the FIFO read latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 3,
    localparam int PTR_W = ptr_width(DEPTH),
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,          // asynchronous, active-low
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [CNT_W-1:0] count_o,
    output logic [WIDTH-1:0] head_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             w_pop;

    // A pop against an empty buffer is ignored so the count can never underflow.
    assign w_pop = pop_i && (count_q != '0);

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = PTR_W'(ptr_wrap_inc(32'(wr_ptr_q), $unsigned(DEPTH)));
        end
        if (w_pop) begin
            rd_ptr_d = PTR_W'(ptr_wrap_inc(32'(rd_ptr_q), $unsigned(DEPTH)));
        end
        case ({push_i, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers and storage; reset discards any held words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

    assign count_o     = count_q;
    assign head_data_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule : fifo_rd_skid_buf
`default_nettype wire

// File: rtl/fifo_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_reader
//  Description : Drains synchronous_FIFO into a valid/ready stream and counts
//                delivered words.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_reader
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BUF_DEPTH = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,          // asynchronous, active-low
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_r_en,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [CNT_W-1:0] rd_count
);

    localparam int BCNT_W = cnt_width(BUF_DEPTH);

    logic [BCNT_W-1:0] w_buf_count;
    logic              inflight_q;
    logic [CNT_W-1:0]  rd_count_q, rd_count_d;
    logic              w_pop;
    logic [31:0]       w_occupancy;

    // Reserve a buffer slot for every read before issuing it; the in-flight
    // word always has somewhere to land, so no m_ready path is needed here.
    assign w_occupancy = 32'(w_buf_count) + 32'(inflight_q);
    assign fifo_r_en   = rst && en && !fifo_empty
                         && (w_occupancy < $unsigned(BUF_DEPTH));

    assign w_pop   = m_valid && m_ready;
    assign m_valid = (w_buf_count != '0);

    fifo_rd_skid_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (fifo_rdata),
        .pop_i       (w_pop),
        .count_o     (w_buf_count),
        .head_data_o (m_data)
    );

    // Delivered-word counter, wraps naturally at 2^CNT_W.
    always_comb begin
        rd_count_d = rd_count_q;
        if (w_pop) begin
            rd_count_d = rd_count_q + 1'b1;
        end
    end

    // In-flight flag tracks the FIFO's one-cycle read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= 1'b0;
            rd_count_q <= '0;
        end else begin
            inflight_q <= fifo_r_en;
            rd_count_q <= rd_count_d;
        end
    end

    assign rd_count = rd_count_q;

endmodule : fifo_reader
`default_nettype wire

// File: tb/tb_fifo_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_reader
//  Description : Directed self-checking bench for fifo_reader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_reader;
    import fifo_rd_pkg::*;

    localparam int WIDTH     = 8;
    localparam int BUF_DEPTH = 3;
    localparam int CNT_W     = 4;

    logic             clk     = 1'b0;
    logic             rst     = 1'b0;
    logic             en      = 1'b0;
    logic             m_ready = 1'b0;
    logic             fifo_empty;
    logic             fifo_r_en;
    logic             m_valid;
    word_t            fifo_rdata = '0;
    word_t            m_data;
    logic [CNT_W-1:0] rd_count;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_reader #(
        .WIDTH     (WIDTH),
        .BUF_DEPTH (BUF_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_r_en  (fifo_r_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .rd_count   (rd_count)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous_FIFO: registered data_out, one-cycle latency.
    word_t fmem [0:127];
    int    f_wr = 0;
    int    f_rd = 0;
    assign fifo_empty = (f_rd == f_wr);

    always @(posedge clk) begin
        if (fifo_r_en && !fifo_empty) begin
            fifo_rdata <= fmem[f_rd];
            f_rd       <= f_rd + 1;
        end
    end

    // Output monitor: records every accepted transfer and every read strobe.
    word_t rx_q [$];
    int    ren_cnt = 0;
    always @(negedge clk) begin
        if (m_valid && m_ready) rx_q.push_back(m_data);
        if (fifo_r_en) ren_cnt <= ren_cnt + 1;
    end

    // Buffered plus in-flight words must never exceed the buffer size.
    always @(negedge clk) begin
        if (rst) begin
            assert (32'(dut.w_buf_count) + 32'(dut.inflight_q) <= BUF_DEPTH)
            else $error("FAIL occupancy: count=%0d inflight=%0d limit=%0d",
                        dut.w_buf_count, dut.inflight_q, BUF_DEPTH);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fifo(input word_t w);
        fmem[f_wr] = w;
        f_wr = f_wr + 1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            step();
            k++;
        end
    endtask

    // Compare received words base..base+n-1 against first, first+1, ...
    task automatic check_rx(input string tag, input int base, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d]", tag, i),
                  (base + i < rx_q.size()) ? 32'(rx_q[base + i]) : 32'hDEAD,
                  32'(first + i));
        end
    endtask

    initial begin
        logic [15:0] ren_v;
        logic [15:0] mv_v;
        word_t       md;
        int          base;
        int          r0;

        // ---- Reset held with en=1 and a non-empty FIFO ----
        rst = 1'b0; en = 1'b1; m_ready = 1'b1;
        push_fifo(8'hA5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ren",   fifo_r_en, 0);
            check("rst_valid", m_valid,   0);
            check("rst_count", rd_count,  0);
        end

        // ---- Single word ----
        step();
        rst  = 1'b1;
        base = rx_q.size();
        ren_v = '0; mv_v = '0; md = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ren_v[i] = fifo_r_en;
            mv_v[i]  = m_valid;
            if (m_valid) md = m_data;
        end
        check("single_ren",   ren_v,    16'h0001);
        check("single_valid", mv_v,     16'h0004);
        check("single_data",  md,       8'hA5);
        check("single_count", rd_count, 1);

        // ---- Streaming 0x01..0x08 ----
        step();
        do_reset();
        base = rx_q.size();
        for (int i = 1; i <= 8; i++) push_fifo(word_t'(i));
        mv_v = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            mv_v[i] = m_valid;
        end
        step();
        check("stream_valid", mv_v, 16'h03FC);
        check("stream_n",     rx_q.size() - base, 8);
        check_rx("stream_data", base, 1, 8);
        check("stream_count", rd_count,   8);
        check("stream_empty", fifo_empty, 1);

        // ---- Backpressure ----
        m_ready = 1'b0;
        do_reset();
        r0   = ren_cnt;
        base = rx_q.size();
        for (int i = 1; i <= 8; i++) push_fifo(word_t'(i));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                check("bp_hold_valid", m_valid, 1);
                check("bp_hold_data",  m_data,  8'h01);
            end
        end
        step();
        check("bp_reads", ren_cnt - r0, 3);
        m_ready = 1'b1;
        mv_v = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            mv_v[i] = m_valid;
        end
        step();
        check("bp_valid", mv_v, 16'h00FF);
        check("bp_n",     rx_q.size() - base, 8);
        check_rx("bp_data", base, 1, 8);
        check("bp_count", rd_count, 8);

        // ---- en dropped after the second read ----
        do_reset();
        base = rx_q.size();
        for (int i = 1; i <= 4; i++) push_fifo(word_t'(i));
        @(negedge clk);
        step();
        @(negedge clk);
        step();
        en = 1'b0;
        ren_v = '0; mv_v = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ren_v[i] = fifo_r_en;
            mv_v[i]  = m_valid;
        end
        step();
        check("en_ren",   ren_v, 16'h0000);
        check("en_valid", mv_v,  16'h0003);
        check("en_n",     rx_q.size() - base, 2);
        en = 1'b1;
        wait_rx(base + 4, 20);
        step();
        check("en_n_all", rx_q.size() - base, 4);
        check_rx("en_data", base, 1, 4);
        check("en_count", rd_count,   4);
        check("en_empty", fifo_empty, 1);

        // ---- Async reset with 2 buffered + 1 in flight ----
        m_ready = 1'b0;
        base = rx_q.size();
        for (int i = 1; i <= 6; i++) push_fifo(word_t'(i));
        step();
        step();
        step();
        check("arst_pre_valid", m_valid,  1);
        check("arst_pre_count", rd_count, 4);
        #1 rst = 1'b0;
        #1;
        check("arst_valid", m_valid,   0);
        check("arst_count", rd_count,  0);
        check("arst_ren",   fifo_r_en, 0);
        #1 rst = 1'b1;
        m_ready = 1'b1;
        wait_rx(base + 3, 20);
        step();
        step();
        check("arst_n", rx_q.size() - base, 3);
        check_rx("arst_data", base, 4, 3);
        check("arst_post_count", rd_count, 3);

        // ---- rd_count wraps after 16 transfers ----
        do_reset();
        base = rx_q.size();
        for (int i = 0; i < 16; i++) push_fifo(word_t'(8'h10 + i));
        wait_rx(base + 16, 40);
        step();
        step();
        check("wrap_n",     rx_q.size() - base, 16);
        check_rx("wrap_data", base, 8'h10, 16);
        check("wrap_count", rd_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fifo_reader
`default_nettype wire
